// File: rtl/bpf_regfile_pkg.sv
// Shared constants and read-port request/response types for the BPF operand register file.
// The default build is read-first. Define BPF_REGFILE_BYPASS_EN to get write-first forwarding instead.
package bpf_regfile_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 4;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_AW    = 5;

    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Fields are sized for the largest legal configuration; narrower builds zero-pad.
    typedef struct packed {
        logic              re;
        logic [MAX_AW-1:0] raddr;
    } rd_req_t;

    typedef struct packed {
        logic                 rvalid;
        logic                 rerr;
        logic [MAX_WIDTH-1:0] rdata;
    } rd_rsp_t;

endpackage

// File: rtl/bpf_regfile_rdport.sv
// One registered read port: index decode mux, range check, optional write forwarding, output register.
// The forwarding inputs exist only when BPF_REGFILE_BYPASS_EN is defined.
module bpf_regfile_rdport
    import bpf_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  regs [NREGS],
`ifdef BPF_REGFILE_BYPASS_EN
    input  logic              wr_fwd,
    input  logic [MAX_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
`endif
    input  rd_req_t           req,
    output rd_rsp_t           rsp
);

    localparam logic [MAX_AW:0] NREGS_X = (MAX_AW + 1)'(NREGS);

    logic             in_range;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             rerr_q;

    assign in_range = {1'b0, req.raddr} < NREGS_X;

    // An out-of-range index matches no entry, so sel falls through to zero.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (req.raddr == MAX_AW'(i)) begin
                sel = regs[i];
            end
        end
`ifdef BPF_REGFILE_BYPASS_EN
        if (wr_fwd && (req.raddr == waddr)) begin
            sel = wdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= req.re;
            rerr_q   <= req.re && !in_range;
            if (req.re) begin
                rdata_q <= sel;
            end
        end
    end

    assign rsp = '{rvalid: rvalid_q, rerr: rerr_q, rdata: MAX_WIDTH'(rdata_q)};

endmodule

// File: rtl/bpf_regfile.sv
// BPF operand register file: one write port and two registered read ports with 1-cycle latency.
// Define BPF_REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module bpf_regfile
    import bpf_regfile_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NREGS = DEF_NREGS,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    output logic             rvalid0,
    output logic             rerr0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    output logic             rerr1
);

    localparam logic [AW:0] NREGS_X = (AW + 1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_ok;
    rd_req_t          req0;
    rd_req_t          req1;
    rd_rsp_t          rsp0;
    rd_rsp_t          rsp1;
    logic             unused_rsp_hi;

    assign wr_ok = we && ({1'b0, waddr} < NREGS_X);

    // clr wins over a same-cycle write; out-of-range writes never match an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && (waddr == AW'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    assign req0 = '{re: re0, raddr: MAX_AW'(raddr0)};
    assign req1 = '{re: re1, raddr: MAX_AW'(raddr1)};

`ifdef BPF_REGFILE_BYPASS_EN
    logic wr_fwd;
    assign wr_fwd = wr_ok && !clr;
`endif

    bpf_regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rd0 (
        .clk    (clk),
        .rst    (rst),
        .regs   (regs),
`ifdef BPF_REGFILE_BYPASS_EN
        .wr_fwd (wr_fwd),
        .waddr  (MAX_AW'(waddr)),
        .wdata  (wdata),
`endif
        .req    (req0),
        .rsp    (rsp0)
    );

    bpf_regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rd1 (
        .clk    (clk),
        .rst    (rst),
        .regs   (regs),
`ifdef BPF_REGFILE_BYPASS_EN
        .wr_fwd (wr_fwd),
        .waddr  (MAX_AW'(waddr)),
        .wdata  (wdata),
`endif
        .req    (req1),
        .rsp    (rsp1)
    );

    assign rdata0  = rsp0.rdata[WIDTH-1:0];
    assign rvalid0 = rsp0.rvalid;
    assign rerr0   = rsp0.rerr;
    assign rdata1  = rsp1.rdata[WIDTH-1:0];
    assign rvalid1 = rsp1.rvalid;
    assign rerr1   = rsp1.rerr;

    // Upper response bits are zero padding from the shared response type.
    assign unused_rsp_hi = ^{rsp0.rdata, rsp1.rdata};

endmodule

// File: tb/tb_bpf_regfile.sv
// Bench for bpf_regfile: three configurations (8x4, 8x5, 32x16) share one stimulus stream,
// each checked every cycle against a per-configuration behavioural model plus literal expectations.
module tb_bpf_regfile;

`ifdef BPF_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        we  = 1'b0;
    logic        re0 = 1'b0;
    logic        re1 = 1'b0;
    logic [4:0]  waddr  = '0;
    logic [4:0]  raddr0 = '0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] wdata  = '0;

    logic [7:0]  a_rd0, a_rd1, b_rd0, b_rd1;
    logic [31:0] c_rd0, c_rd1;
    logic        a_v0, a_v1, a_e0, a_e1;
    logic        b_v0, b_v1, b_e0, b_e1;
    logic        c_v0, c_v1, c_e0, c_e1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bpf_regfile u_a (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[1:0]), .wdata(wdata[7:0]),
        .re0(re0), .raddr0(raddr0[1:0]), .rdata0(a_rd0), .rvalid0(a_v0), .rerr0(a_e0),
        .re1(re1), .raddr1(raddr1[1:0]), .rdata1(a_rd1), .rvalid1(a_v1), .rerr1(a_e1)
    );

    bpf_regfile #(.NREGS(5)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
        .re0(re0), .raddr0(raddr0[2:0]), .rdata0(b_rd0), .rvalid0(b_v0), .rerr0(b_e0),
        .re1(re1), .raddr1(raddr1[2:0]), .rdata1(b_rd1), .rvalid1(b_v1), .rerr1(b_e1)
    );

    bpf_regfile #(.WIDTH(32), .NREGS(16)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[3:0]), .wdata(wdata),
        .re0(re0), .raddr0(raddr0[3:0]), .rdata0(c_rd0), .rvalid0(c_v0), .rerr0(c_e0),
        .re1(re1), .raddr1(raddr1[3:0]), .rdata1(c_rd1), .rvalid1(c_v1), .rerr1(c_e1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int nr  [3] = '{4, 5, 16};
    int awb [3] = '{2, 3, 4};
    int wb  [3] = '{8, 8, 32};

    logic [31:0] mem  [3][32];
    logic [31:0] e_d  [3][2];
    logic        e_v  [3][2];
    logic        e_e  [3][2];
    logic [31:0] act_d[3][2];
    logic        act_v[3][2];
    logic        act_e[3][2];

    function automatic logic [31:0] dmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    always @(posedge clk or posedge rst) begin
        int          wa, ra, am;
        logic [31:0] wd;
        bit          wok, r;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 32; i++) mem[k][i] = '0;
                for (int p = 0; p < 2; p++) begin
                    e_d[k][p] = '0; e_v[k][p] = 1'b0; e_e[k][p] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                am  = (1 << awb[k]) - 1;
                wa  = int'(waddr) & am;
                wd  = wdata & dmask(wb[k]);
                wok = we && (wa < nr[k]);
                for (int p = 0; p < 2; p++) begin
                    r  = (p == 0) ? re0 : re1;
                    ra = int'((p == 0) ? raddr0 : raddr1) & am;
                    e_v[k][p] = r;
                    if (!r) begin
                        e_e[k][p] = 1'b0;
                    end else if (ra >= nr[k]) begin
                        e_e[k][p] = 1'b1;
                        e_d[k][p] = '0;
                    end else begin
                        e_e[k][p] = 1'b0;
                        e_d[k][p] = (BYP && wok && !clr && ra == wa) ? wd : mem[k][ra];
                    end
                end
                if (clr) begin
                    for (int i = 0; i < 32; i++) mem[k][i] = '0;
                end else if (wok) begin
                    mem[k][wa] = wd;
                end
            end
        end
    end

    always_comb begin
        act_d[0][0] = 32'(a_rd0); act_v[0][0] = a_v0; act_e[0][0] = a_e0;
        act_d[0][1] = 32'(a_rd1); act_v[0][1] = a_v1; act_e[0][1] = a_e1;
        act_d[1][0] = 32'(b_rd0); act_v[1][0] = b_v0; act_e[1][0] = b_e0;
        act_d[1][1] = 32'(b_rd1); act_v[1][1] = b_v1; act_e[1][1] = b_e1;
        act_d[2][0] = c_rd0;      act_v[2][0] = c_v0; act_e[2][0] = c_e0;
        act_d[2][1] = c_rd1;      act_v[2][1] = c_v1; act_e[2][1] = c_e1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("model.i%0d.p%0d.rvalid", k, p), 32'(act_v[k][p]), 32'(e_v[k][p]));
                chk($sformatf("model.i%0d.p%0d.rerr", k, p), 32'(act_e[k][p]), 32'(e_e[k][p]));
                chk($sformatf("model.i%0d.p%0d.rdata", k, p), act_d[k][p], e_d[k][p]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    logic [7:0] exp_b [5];

    initial begin
        exp_b = '{8'h11, 8'h7E, 8'h33, 8'h44, 8'h00};

        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset.rvalid0", 32'(a_v0), 32'd0);
        chk("reset.rdata0", 32'(a_rd0), 32'd0);

        // async reset with a read in flight
        wr(5'd2, 32'h5A);
        re0 = 1'b1; raddr0 = 5'd2;
        tick();
        chk("pre_rst.rdata0", 32'(a_rd0), 32'h5A);
        chk("pre_rst.rvalid0", 32'(a_v0), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst.rdata0", 32'(a_rd0), 32'd0);
        chk("async_rst.rvalid0", 32'(a_v0), 32'd0);
        chk("async_rst.c_rdata0", c_rd0, 32'd0);
        tick();
        rst = 1'b0; re0 = 1'b0;
        tick();
        chk("post_rst.rvalid0", 32'(a_v0), 32'd0);

        wr(5'd2, 32'hA5);
        re0 = 1'b1; raddr0 = 5'd2;
        tick();
        re0 = 1'b0;
        chk("wr_rd.rdata0", 32'(a_rd0), 32'hA5);
        chk("wr_rd.rvalid0", 32'(a_v0), 32'd1);
        chk("wr_rd.c_rdata0", c_rd0, 32'hA5);

        // dual-port read
        for (int i = 0; i < 4; i++) wr(5'(i), 32'h11 * (i + 1));
        re0 = 1'b1; raddr0 = 5'd3; re1 = 1'b1; raddr1 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dual.rdata0", 32'(a_rd0), 32'h44);
            chk("dual.rdata1", 32'(a_rd1), 32'h11);
            chk("dual.rvalid1", 32'(a_v1), 32'd1);
        end
        re1 = 1'b0;

        // same-cycle write/read
        raddr0 = 5'd1; we = 1'b1; waddr = 5'd1; wdata = 32'h7E;
        tick();
        we = 1'b0;
        chk("rw_same.rdata0", 32'(a_rd0), BYP ? 32'h7E : 32'h22);
        tick();
        chk("rw_next.rdata0", 32'(a_rd0), 32'h7E);

        // out of range on the 5-entry instance
        raddr0 = 5'd6;
        tick();
        chk("oor.b_rdata0", 32'(b_rd0), 32'd0);
        chk("oor.b_rvalid0", 32'(b_v0), 32'd1);
        chk("oor.b_rerr0", 32'(b_e0), 32'd1);
        chk("oor.a_rdata0", 32'(a_rd0), 32'h33);
        raddr0 = 5'd0;
        tick();
        chk("oor_clear.b_rerr0", 32'(b_e0), 32'd0);
        re0 = 1'b0;
        raddr0 = 5'd6; re0 = 1'b1;
        tick();
        re0 = 1'b0;
        tick();
        chk("oor_idle.b_rerr0", 32'(b_e0), 32'd0);
        wr(5'd7, 32'h99);
        re0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            raddr0 = 5'(i);
            tick();
            chk($sformatf("oor_wr.b_reg%0d", i), 32'(b_rd0), 32'(exp_b[i]));
        end

        // clear priority, read during clear sees old contents
        raddr0 = 5'd3; clr = 1'b1; we = 1'b1; waddr = 5'd0; wdata = 32'hFF;
        tick();
        clr = 1'b0; we = 1'b0;
        chk("clr_read.a_rdata0", 32'(a_rd0), 32'h99);
        for (int i = 0; i < 4; i++) begin
            raddr0 = 5'(i);
            tick();
            chk($sformatf("clr.a_reg%0d", i), 32'(a_rd0), 32'd0);
        end

        // same-address on both ports
        re0 = 1'b0;
        wr(5'd2, 32'h3C);
        re0 = 1'b1; re1 = 1'b1; raddr0 = 5'd2; raddr1 = 5'd2;
        tick();
        chk("same_addr.rdata0", 32'(a_rd0), 32'h3C);
        chk("same_addr.rdata1", 32'(a_rd1), 32'h3C);

        // random sweep across all three configurations
        for (int n = 0; n < 1000; n++) begin
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            re0    = 1'($urandom_range(0, 1));
            re1    = 1'($urandom_range(0, 1));
            raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr1 = 5'($urandom_range(0, 31));
            clr    = ($urandom_range(0, 63) == 0);
            if (n == 500) rst = 1'b1;
            if (n == 502) rst = 1'b0;
            tick();
        end

        we = 1'b0; re0 = 1'b0; re1 = 1'b0; clr = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
